sram_like_slave: RTL and testbench
==================================

# sram_like_slave

Responder end of the SRAM-like bus used by the pipeline's instruction and data ports. It accepts `req`/`addr_ok` handshakes and issues each accepted access to a single-port synchronous RAM. It returns exactly one `data_ok` per accepted request, in order, a fixed number of cycles later. The block is instantiated once per port (inst, data) in the SoC-lite testbench and in simulation top levels, in place of the AXI bridge.

## Interface
- `ADDR_W`, default 14: RAM word-address width; capacity is 2^ADDR_W 32-bit words.
- `LATENCY`, default 1, legal 1..8: cycles from an accept edge to the matching `data_ok` cycle.
- `DEPTH`, default 2, legal 1..8: maximum number of accepted requests awaiting `data_ok`.

- `clk`  in  1: clock; all state changes on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `req`  in  1: master request.
- `wr`  in  1: 1 = write, 0 = read.
- `size`  in  2: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `addr`  in  32: byte address.
- `wdata`  in  32: write data, already lane-positioned by the master.
- `hold`  in  1: backpressure injection; while 1, `addr_ok` = 0.
- `addr_ok`  out  1: request accepted this cycle when `req` && `addr_ok`.
- `rdata`  out  32: read data, valid while `data_ok` = 1.
- `data_ok`  out  1: one-cycle response pulse per accepted request.
- `ram_en`  out  1: RAM access strobe.
- `ram_we`  out  4: RAM byte write enables.
- `ram_addr`  out  ADDR_W: RAM word address.
- `ram_wdata`  out  32: RAM write data.
- `ram_rdata`  in  32: RAM read data, valid the cycle after `ram_en`.

## Operation
- `addr_ok` = `resetn` && !`hold` && (`outstanding` < DEPTH || `data_ok`). It is combinational and may depend on `req`-independent state only. A simultaneous retire frees a slot in the same cycle.
- Accept (`req` && `addr_ok`) drives `ram_en` = 1 in the same cycle, with `ram_addr` = `addr[ADDR_W+1:2]` and `ram_wdata` = `wdata`. Address bits above ADDR_W+1 are ignored (aliasing).
- `ram_we` is all-zero for reads. For writes it is set as follows:
  - size 0: one-hot on `addr[1:0]`.
  - size 1: 4'b0011 if `addr[1]` = 0, else 4'b1100.
  - size 2 and 3: 4'b1111.
- Misaligned low bits are not checked; the access proceeds with the rules above.
- Response delay line:
  - LATENCY stages of {valid, is_read}.
  - Stage 0 is loaded at the accept edge.
  - Captured read data is registered from `ram_rdata` in the cycle after accept, then shifted along with the line.
- `data_ok` = valid of the last stage.
- `rdata` = captured `ram_rdata` for reads; 32'h0 for writes and when `data_ok` = 0.
- `outstanding` counter, width clog2(DEPTH+1):
  - +1 on accept, −1 on `data_ok`, unchanged when both or neither occur.
  - Never exceeds DEPTH and never underflows; add an assertion for each.
- Responses are strictly in acceptance order. At most one accept and one retire occur per cycle.

## Timing
- Reset, while `resetn` = 0:
  - Asynchronously clear all delay-line valids and `outstanding`.
  - `addr_ok` = 0, `data_ok` = 0, `rdata` = 0, `ram_en` = 0, `ram_we` = 0.
- First accept is possible in the first cycle with `resetn` = 1.
- Accept at edge k gives `data_ok` = 1 during cycle k+LATENCY, for exactly one cycle.
- Throughput is one request per cycle when DEPTH ≥ LATENCY. Otherwise the limit is DEPTH requests per LATENCY cycles.
- Reset asserted mid-operation drops all in-flight responses. No `data_ok` is produced for them after reset release.
- A write's RAM update completes at its accept edge. A read accepted in the next cycle to the same word returns the new data.
- Inputs are sampled only in the accept cycle. The master may change `addr`/`wdata`/`wr`/`size` freely after the handshake.

## Test plan
- Reset: hold `resetn` = 0 with `req` = 1 → `addr_ok` = 0, `data_ok` = 0, `ram_en` = 0. After release, the first read is accepted in cycle 1.
- Single read, LATENCY = 1: RAM word 5 = 32'hDEADBEEF; read `addr` 0x14 accepted at edge k → `data_ok` = 1 in cycle k+1 with `rdata` = 32'hDEADBEEF.
- Back-to-back reads, LATENCY = 3, DEPTH = 4: four consecutive accepts to words 0..3 → four consecutive `data_ok` pulses starting at k+3, data in order, `addr_ok` never dropped.
- Full stall, LATENCY = 3, DEPTH = 2: continuous `req` → `addr_ok` pattern 1,1,0,1,1,0…; `outstanding` never exceeds 2.
- Byte/half writes: writes of byte 0xAA at 0x21, half 0xBBBB at 0x22, then a word read of 0x20 → `ram_we` 4'b0010 then 4'b1100; readback 32'hBBBBAA00 (word pre-zeroed).
- `hold` and reset mid-flight: `hold` = 1 for 3 cycles → no accepts. Then accept two reads and pulse `resetn` low before the responses return → no `data_ok` afterward, `outstanding` = 0.

Source files
------------

// File: rtl/sram_like_slave.sv
// SRAM-like bus responder: accepts req/addr_ok handshakes, drives a
// single-port sync RAM and returns in-order data_ok after LATENCY cycles.
module sram_like_slave #(
  parameter int ADDR_W  = 14,
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              hold,
  output logic              addr_ok,
  output logic [31:0]       rdata,
  output logic              data_ok,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]   outstanding;
  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] is_rd;
  logic               accept;
  logic [3:0]         wmask;
  logic [31:0]        last_data;
  logic               unused_hi;

  assign unused_hi = ^addr[31:ADDR_W+2];

  assign data_ok = vld[LATENCY-1];
  assign addr_ok = resetn && !hold
                && (outstanding < DEPTH_C || data_ok);
  assign accept  = req && addr_ok;

  always_comb begin
    wmask = 4'b0000;
    unique case (1'b1)
      (size == 2'd0): wmask = 4'b0001 << addr[1:0];
      (size == 2'd1): wmask = addr[1] ? 4'b1100 : 4'b0011;
      default:        wmask = 4'b1111;
    endcase
  end

  assign ram_en    = accept;
  assign ram_we    = (accept && wr) ? wmask : 4'b0000;
  assign ram_addr  = addr[ADDR_W+1:2];
  assign ram_wdata = wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld   <= '0;
      is_rd <= '0;
    end else begin
      vld[0]   <= accept;
      is_rd[0] <= accept && !wr;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]   <= vld[i-1];
        is_rd[i] <= is_rd[i-1];
      end
    end
  end

  // RAM data appears while stage 0 is valid; later stages see it registered
  generate
    if (LATENCY == 1) begin : g_l1
      assign last_data = ram_rdata;
    end else begin : g_ln
      logic [31:0] dq [LATENCY-1];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int i = 0; i < LATENCY - 1; i++) dq[i] <= '0;
        end else begin
          dq[0] <= ram_rdata;
          for (int i = 1; i < LATENCY - 1; i++) dq[i] <= dq[i-1];
        end
      end
      assign last_data = dq[LATENCY-2];
    end
  endgenerate

  assign rdata = (data_ok && is_rd[LATENCY-1]) ? last_data : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
    end else if (accept && !data_ok) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!accept && data_ok) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(accept && !data_ok && outstanding == DEPTH_C));

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(data_ok && !accept && outstanding == '0));

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: three configurations share one stimulus,
// each with its own RAM, reference memory and response scoreboard.
module tb_sram_like_slave;

  localparam int AW = 6;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [2:0]  reqv;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hold;

  logic [2:0]    ok_v, dok_v, en_v;
  logic [31:0]   rd_v   [3];
  logic [3:0]    we_v   [3];
  logic [AW-1:0] ra_v   [3];
  logic [31:0]   rw_v   [3];
  logic [3:0]    outs_v [3];

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;
  bit stop = 1'b0;

  logic [31:0] ref_mem [3][NW];
  logic [31:0] qd [3][$];
  int          qc [3][$];
  logic [31:0] last_rd [3];
  logic [3:0]  last_we [3];
  int          ndok [3];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    nvec++;
    if (obs !== expv) begin
      nbad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    if (i == 8) return 32'h0;
    return {i[7:0], 8'hA5, ~i[7:0], 8'h3C};
  endfunction

  function automatic logic [3:0] exp_we(input logic w,
                                        input logic [1:0] s,
                                        input logic [1:0] a);
    if (!w) return 4'b0000;
    case (s)
      2'd0:    return 4'b0001 << a;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int DEP = (g == 1) ? 4 : 2;

    logic          addr_ok, data_ok, ram_en;
    logic [31:0]   rdata, ram_wdata, ram_rdata;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   mem [NW];

    initial begin
      for (int i = 0; i < NW; i++) mem[i] = init_word(i);
    end

    always @(posedge clk) begin
      if (ram_en) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_addr];
      end
    end

    sram_like_slave #(
      .ADDR_W (AW),
      .LATENCY(LAT),
      .DEPTH  (DEP)
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (reqv[g]),
      .wr       (wr),
      .size     (size),
      .addr     (addr),
      .wdata    (wdata),
      .hold     (hold),
      .addr_ok  (addr_ok),
      .rdata    (rdata),
      .data_ok  (data_ok),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
    );

    assign ok_v[g]   = addr_ok;
    assign dok_v[g]  = data_ok;
    assign en_v[g]   = ram_en;
    assign rd_v[g]   = rdata;
    assign we_v[g]   = ram_we;
    assign ra_v[g]   = ram_addr;
    assign rw_v[g]   = ram_wdata;
    assign outs_v[g] = 4'(u_dut.outstanding);
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] m, input logic w,
                       input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int n);
    logic [2:0] pend;
    pend = m;
    wr = w; size = s; addr = a; wdata = d;
    reqv = pend;
    n = 0;
    while (pend != 3'b000 && n < 40) begin
      @(negedge clk);
      pend = pend & ~ok_v;
      @(posedge clk);
      #1;
      reqv = pend;
      n++;
    end
    chk("issue_timeout", pend, 3'b000);
  endtask

  initial begin
    int n;
    int d1, d2;
    int stall_n [8];
    stall_n = '{1, 1, 2, 1, 2, 1, 2, 1};
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < NW; i++) ref_mem[g][i] = init_word(i);
      last_rd[g] = 32'h0;
      last_we[g] = 4'h0;
      ndok[g] = 0;
    end
    resetn = 1'b0; reqv = 3'b111; wr = 1'b0; size = 2'd2;
    addr = 32'h14; wdata = 32'h0; hold = 1'b0;

    fork
      begin : mon
        logic acc;
        logic [31:0] ed;
        int ec;
        logic [AW-1:0] w;
        logic [3:0] we;
        while (!stop) begin
          @(negedge clk);
          cyc++;
          for (int g = 0; g < 3; g++) begin
            if (!resetn) begin
              qd[g].delete();
              qc[g].delete();
            end else begin
              acc = reqv[g] && ok_v[g];
              chk("ram_en", en_v[g], acc);
              chk("outstanding", outs_v[g], 4'(qd[g].size()));
              chk("dok_no_pending", dok_v[g] && (qd[g].size() == 0), 1'b0);
              if (dok_v[g] && qd[g].size() != 0) begin
                ed = qd[g].pop_front();
                ec = qc[g].pop_front();
                chk("rdata", rd_v[g], ed);
                chk("latency", cyc - ec, lat_of(g));
                last_rd[g] = rd_v[g];
                ndok[g]++;
              end else if (!dok_v[g]) begin
                chk("rdata_idle", rd_v[g], 32'h0);
              end
              if (acc) begin
                w  = addr[AW+1:2];
                we = exp_we(wr, size, addr[1:0]);
                chk("ram_addr", ra_v[g], w);
                chk("ram_we", we_v[g], we);
                chk("ram_wdata", rw_v[g], wdata);
                last_we[g] = we_v[g];
                if (wr) begin
                  for (int b = 0; b < 4; b++)
                    if (we[b]) ref_mem[g][w][8*b +: 8] = wdata[8*b +: 8];
                  qd[g].push_back(32'h0);
                end else begin
                  qd[g].push_back(ref_mem[g][w]);
                end
                qc[g].push_back(cyc);
              end
            end
          end
        end
      end

      begin : stim
        repeat (3) begin
          @(negedge clk);
          chk("rst_addr_ok", ok_v, 3'b000);
          chk("rst_data_ok", dok_v, 3'b000);
          chk("rst_ram_en", en_v, 3'b000);
          chk("rst_rdata", rd_v[0], 32'h0);
        end
        @(posedge clk);
        #1;
        reqv = 3'b000;
        resetn = 1'b1;

        issue(3'b111, 1'b0, 2'd2, 32'h14, 32'h0, n);
        chk("first_accept", n, 1);
        idle(6);
        for (int g = 0; g < 3; g++) begin
          chk("single_read", last_rd[g], 32'hDEADBEEF);
          chk("single_count", ndok[g], 1);
        end

        for (int i = 0; i < 4; i++) begin
          issue(3'b010, 1'b0, 2'd2, 32'(i * 4), 32'h0, n);
          chk("b2b_addr_ok", n, 1);
        end
        idle(6);
        chk("b2b_count", ndok[1], 5);

        for (int i = 0; i < 8; i++) begin
          issue(3'b100, 1'b0, 2'd2, 32'(i * 4), 32'h0, n);
          chk("stall_pattern", n, stall_n[i]);
        end
        idle(8);
        chk("stall_count", ndok[2], 9);

        issue(3'b111, 1'b1, 2'd0, 32'h21, 32'h0000AA00, n);
        chk("we_byte", last_we[0], 4'b0010);
        issue(3'b111, 1'b1, 2'd1, 32'h22, 32'hBBBB0000, n);
        chk("we_half", last_we[0], 4'b1100);
        issue(3'b111, 1'b0, 2'd2, 32'h20, 32'h0, n);
        idle(6);
        for (int g = 0; g < 3; g++)
          chk("byte_half_readback", last_rd[g], 32'hBBBBAA00);

        issue(3'b111, 1'b1, 2'd3, 32'h130, 32'h12345678, n);
        chk("we_size3", last_we[2], 4'b1111);
        issue(3'b111, 1'b0, 2'd2, 32'h30, 32'h0, n);
        idle(6);
        for (int g = 0; g < 3; g++)
          chk("alias_readback", last_rd[g], 32'h12345678);

        hold = 1'b1;
        reqv = 3'b111;
        repeat (3) begin
          @(negedge clk);
          chk("hold_addr_ok", ok_v, 3'b000);
        end
        @(posedge clk);
        #1;
        reqv = 3'b000;
        hold = 1'b0;

        d1 = ndok[1];
        d2 = ndok[2];
        issue(3'b110, 1'b0, 2'd2, 32'h8, 32'h0, n);
        issue(3'b110, 1'b0, 2'd2, 32'hC, 32'h0, n);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(8);
        chk("flush_dok_l3d4", ndok[1], d1);
        chk("flush_dok_l3d2", ndok[2], d2);
        chk("flush_outs_l3d4", outs_v[1], 4'd0);
        chk("flush_outs_l3d2", outs_v[2], 4'd0);

        issue(3'b111, 1'b0, 2'd2, 32'h14, 32'h0, n);
        chk("post_reset_accept", n, 1);
        idle(6);
        chk("post_reset_read", last_rd[0], 32'hDEADBEEF);
        stop = 1'b1;
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
